// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that lets several APB masters share one APB slave bus.
// It has an IDLE/SETUP/ACCESS FSM, an address-decoded slave select, and timeout and decode-error completion.
module apb_rr_arbiter #(
  parameter int MASTER_PORTS = 2,
  parameter int SLAVE_PORTS  = 4,
  parameter int BUS_WIDTH    = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]           S_PWRITE,
  input  logic [MASTER_PORTS-1:0]           S_PSELx,
  input  logic [MASTER_PORTS-1:0]           S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]           S_PREADY,
  output logic [BUS_WIDTH-1:0]              M_PADDR,
  output logic                              M_PWRITE,
  output logic [SLAVE_PORTS-1:0]            M_PSELx,
  output logic                              M_PENABLE,
  output logic [BUS_WIDTH-1:0]              M_PWDATA,
  input  logic [BUS_WIDTH-1:0]              M_PRDATA,
  input  logic                              M_PREADY,
  output logic                              err
);

  localparam int GW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant, last_grant, pick, cand;
  logic            found;
  logic [7:0]      cnt;
  logic [BUS_WIDTH-1:0] sel_addr, sel_wdata;
  logic            sel_write;
  logic [3:0]      slv_idx;
  logic            hit, dec_err, timeout, done;
  logic            unused_penable;

  // Arbitration ignores PENABLE.
  assign unused_penable = ^S_PENABLE;

  // Round-robin search starts just above the last winner and wraps around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < MASTER_PORTS; k++) begin
      cand = GW'((32'(last_grant) + 32'd1 + k) % 32'(MASTER_PORTS));
      if (!found && S_PSELx[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned i = 0; i < MASTER_PORTS; i++) begin
      if (grant == GW'(i)) begin
        sel_addr  = S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
        sel_wdata = S_PWDATA[i*BUS_WIDTH +: BUS_WIDTH];
        sel_write = S_PWRITE[i];
      end
    end
  end

  assign slv_idx = sel_addr[11:8];

  always_comb begin
    hit = 1'b0;
    for (int unsigned j = 0; j < SLAVE_PORTS; j++) begin
      if (slv_idx == 4'(j)) hit = 1'b1;
    end
  end

  assign dec_err = !hit;
  assign timeout = (cnt == 8'(TIMEOUT - 1));
  assign done    = (state == ACCESS) && (dec_err || M_PREADY || timeout);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(MASTER_PORTS - 1);
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        grant      <= pick;
        last_grant <= pick;
      end
      if (state == SETUP)       cnt <= '0;
      else if (state == ACCESS) cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    M_PADDR   = '0;
    M_PWRITE  = 1'b0;
    M_PWDATA  = '0;
    M_PSELx   = '0;
    M_PENABLE = 1'b0;
    S_PREADY  = '0;
    S_PRDATA  = '0;
    err       = 1'b0;
    if (state != IDLE) begin
      M_PADDR   = sel_addr;
      M_PWRITE  = sel_write;
      M_PWDATA  = sel_wdata;
      M_PENABLE = (state == ACCESS);
      for (int unsigned j = 0; j < SLAVE_PORTS; j++) begin
        if (slv_idx == 4'(j)) M_PSELx[j] = 1'b1;
      end
    end
    if (done) begin
      // A decode error or a timeout completes with zero read data.
      err = dec_err || !M_PREADY;
      for (int unsigned i = 0; i < MASTER_PORTS; i++) begin
        if (grant == GW'(i)) begin
          S_PREADY[i] = 1'b1;
          if (!dec_err && M_PREADY) S_PRDATA[i*BUS_WIDTH +: BUS_WIDTH] = M_PRDATA;
        end
      end
    end
  end

endmodule

// File: doc/apb_rr_arbiter.md
APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

Interface
REQ-001 SHALL have parameter MASTER_PORTS, default 2, number of requesting APB masters (cores), 1..8.
REQ-002 SHALL have parameter SLAVE_PORTS, default 4, number of APB slaves on shared bus, 1..16.
REQ-003 SHALL have parameter BUS_WIDTH, default 16, address and data width.
REQ-004 SHALL have parameter TIMEOUT, default 255, max ACCESS cycles before forced completion, 1..255.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port S_PADDR  input  MASTER_PORTS*BUS_WIDTH  per-master address, master i at [i*BUS_WIDTH +: BUS_WIDTH].
REQ-008 SHALL have port S_PWRITE  input  MASTER_PORTS  per-master write flag.
REQ-009 SHALL have port S_PSELx  input  MASTER_PORTS  per-master transfer request.
REQ-010 SHALL have port S_PENABLE  input  MASTER_PORTS  per-master enable; ignored by arbitration.
REQ-011 SHALL have port S_PWDATA  input  MASTER_PORTS*BUS_WIDTH  per-master write data.
REQ-012 SHALL have port S_PRDATA  output  MASTER_PORTS*BUS_WIDTH  per-master read data.
REQ-013 SHALL have port S_PREADY  output  MASTER_PORTS  per-master transfer-complete.
REQ-014 SHALL have ports M_PADDR output BUS_WIDTH, M_PWRITE output 1, M_PSELx output SLAVE_PORTS, M_PENABLE output 1, M_PWDATA output BUS_WIDTH: shared bus to slaves.
REQ-015 SHALL have ports M_PRDATA input BUS_WIDTH, M_PREADY input 1: shared slave response.
REQ-016 SHALL have port err  output  1  one-cycle pulse on timeout or decode error.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-018 In IDLE, if any S_PSELx bit is set, SHALL grant the first requester found searching upward (with wrap) from last_grant+1, latch grant index, go to SETUP; else stay IDLE.
REQ-019 SHALL update last_grant to the granted index when leaving IDLE.
REQ-020 SHALL route M_PADDR, M_PWRITE, M_PWDATA from the granted master in SETUP and ACCESS; all zero in IDLE.
REQ-021 SHALL decode slave index = M_PADDR[11:8]; in SETUP and ACCESS assert only M_PSELx[index] when index < SLAVE_PORTS.
REQ-022 SHALL drive M_PENABLE=0 in SETUP and 1 in ACCESS; SETUP always lasts exactly one cycle.
REQ-023 In ACCESS with M_PREADY=1, SHALL assert S_PREADY[grant]=1 and S_PRDATA[grant]=M_PRDATA in the same cycle (combinational), then go IDLE.
REQ-024 SHALL hold S_PREADY and S_PRDATA of all non-granted masters at 0 at all times, and of the granted master at 0 outside completion cycle.
REQ-025 SHALL count ACCESS cycles with an 8-bit counter cleared on entering ACCESS; if the count reaches TIMEOUT without M_PREADY, complete with S_PREADY[grant]=1, S_PRDATA=0, err=1, go IDLE.
REQ-026 If decoded index >= SLAVE_PORTS, SHALL assert no M_PSELx bit and complete in the first ACCESS cycle with S_PRDATA=0, err=1.
REQ-027 Minimum latency: request sampled in IDLE cycle N, SETUP N+1, ACCESS N+2, S_PREADY at N+2 if M_PREADY=1; back-to-back grant earliest N+3.
REQ-028 Requests deasserting mid-grant SHALL not abort the transfer; requests from other masters during SETUP/ACCESS SHALL wait.

Reset
REQ-029 On reset, FSM SHALL go IDLE, last_grant=MASTER_PORTS-1 (so master 0 wins first), counter=0, all outputs 0, including mid-transfer.

Verification
REQ-030 Single read: master 0 PSEL, PADDR=0x0102, slave PRDATA=0xBEEF PREADY=1 -> M_PSELx=0b0010 at N+1, PENABLE at N+2, S_PRDATA[0]=0xBEEF, S_PREADY=0b01 at N+2.
REQ-031 Contention: masters 0 and 1 request simultaneously out of reset -> master 0 served first, master 1 granted at next IDLE; repeated contention alternates 0,1,0,1.
REQ-032 Wait states: slave holds PREADY=0 for 3 ACCESS cycles -> PENABLE held, PADDR stable, S_PREADY pulses once on 4th ACCESS cycle.
REQ-033 Timeout: TIMEOUT=4, PREADY stuck 0 -> S_PREADY and err pulse in 4th ACCESS cycle, S_PRDATA=0, FSM IDLE next cycle.
REQ-034 Decode error: PADDR=0x0F00 with SLAVE_PORTS=4 -> M_PSELx=0 throughout, S_PREADY and err in first ACCESS cycle.
REQ-035 Reset in ACCESS: reset asserted -> next cycle all outputs 0, FSM IDLE, following contention grants master 0.
